sr_latch_ctrl: RTL and testbench
================================

Name: sr_latch_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one gated SR latch between N_REQ requesters.
- Each granted request performs one set or reset write to the latch. The write has three phases: setup (S/R driven, gate low), strobe (gate high), hold (gate low, S/R held).
- Guarantees the latch never sees S=R=1 and that S/R never change while the gate is high.
- Sits between requester logic and the latch's R, S, clk, Q pins.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SETUP_CYC, 1, cycles S/R are stable before the gate rises (>=1).
- STROBE_CYC, 2, cycles the gate is high (>=1).
- HOLD_CYC, 1, cycles S/R are held after the gate falls (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nRst  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester write request; level, held until done.
- op  input  N_REQ  per-requester operation: 1=set, 0=reset. Sampled at grant.
- grant  output  N_REQ  one-hot owner of the latch; all zero when idle.
- done  output  N_REQ  one-hot, one-cycle completion pulse.
- busy  output  1  high in any state other than IDLE.
- latch_S  output  1  drives latch S.
- latch_R  output  1  drives latch R.
- latch_clk  output  1  drives latch gate/clock.
- latch_Q  input  1  latch Q readback.
- err  output  1  sticky readback mismatch flag (see Optional Feature).

Behaviour:
- Reset (nRst=0, asynchronous):
  - grant=0, done=0, busy=0, latch_S=0, latch_R=0, latch_clk=0, err=0.
  - Priority pointer ptr=0. FSM=IDLE.
  - Reset mid-operation aborts immediately. The latch contents are not touched by the controller.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. All outputs are registered.
- IDLE:
  - If req != 0, select the first asserted req scanning from ptr upward, modulo N_REQ.
  - Register grant = one-hot of the selection and op_r = op[sel]. Go to SETUP.
  - If req == 0, remain in IDLE.
- SETUP: latch_S=op_r, latch_R=~op_r, latch_clk=0, for SETUP_CYC cycles. Then go to STROBE.
- STROBE: same S/R, latch_clk=1, for STROBE_CYC cycles. Then go to HOLD.
- HOLD: same S/R, latch_clk=0, for HOLD_CYC cycles. Then go to DONE.
- DONE (one cycle):
  - latch_S=latch_R=0, grant=0, done[sel]=1.
  - ptr = (sel+1) mod N_REQ. Go to IDLE.
- A single phase counter, width clog2(max cycle param)+1, reloads on each phase entry.
- Latency: req sampled in IDLE at edge T. grant and SETUP are visible after T. done is high in cycle T+SETUP_CYC+STROBE_CYC+HOLD_CYC+1 (T+5 with defaults).
- Back-to-back throughput: one write per SETUP_CYC+STROBE_CYC+HOLD_CYC+2 cycles (6 with defaults).
- Invariants:
  - latch_S & latch_R is never 1.
  - latch_clk=1 only in STROBE.
  - S/R are constant across each SETUP..HOLD window.
  - grant is one-hot or zero.
- req deasserted mid-operation: the write still completes and done still pulses (no abort).
- op changes after grant: ignored.
- Simultaneous requests: round-robin; a requester that was just served has lowest priority next.
- New req arriving while busy: queued implicitly by the level req and arbitrated at the next IDLE.

Optional Feature:
- Macro: SR_LATCH_CTRL_READBACK_EN.
- Defined: in the last HOLD cycle, sample latch_Q.
  - If latch_Q != op_r, set err=1 (sticky until nRst).
  - done still pulses normally.
- Undefined: no readback logic; err is tied 0 and latch_Q is unused. The port list is unchanged.

Decomposition:
- Shared include header sr_latch_ctrl_defs.vh holds:
  - State encodings: IDLE=0, SETUP=1, STROBE=2, HOLD=3, DONE=4 (3 bits).
  - Op codes: OP_SET=1, OP_RESET=0.
- One natural sub-module: rr_arbiter (parameter N_REQ), with inputs req and ptr and outputs grant_onehot, sel_index; combinational.
- The FSM and phase counter stay in sr_latch_ctrl.

Test Plan:
- Reset then idle: nRst low for 2 cycles, req=0 for 10 cycles -> all outputs 0, busy=0, latch_clk never rises.
- Single set: req=4'b0001, op=4'b0001 at T -> grant=0001 at T+1; latch_S=1, latch_R=0 from T+1..T+4; latch_clk=1 exactly at T+2,T+3; done=0001 at T+5; latch model Q=1.
- Round-robin: req=4'b1111 held, op=4'b0101 -> grant order 0001,0010,0100,1000,0001; done every 6 cycles; latch_S/latch_R alternate 1/0, 0/1.
- Forbidden-state checker: random req/op for 2000 cycles -> assertion that latch_S&latch_R==0, grant one-hot or zero, and S/R stable while latch_clk=1, never fires.
- Reset mid-strobe: assert nRst=0 during STROBE -> latch_clk, latch_S, latch_R, grant drop in the same cycle; after release, req=0010 is served first only if req0 is low (ptr=0).
- Readback (with SR_LATCH_CTRL_READBACK_EN): latch model forced to Q=0 during a set -> err=1 after HOLD, stays 1 across later writes until nRst; without the macro, err=0.

Source files
------------

// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types and helpers for the SR latch sequencer: FSM encoding, op codes,
// requester index type and pointer wrap helper.
package sr_latch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    // Requester index wide enough for up to 8 requesters.
    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t wrap_inc(input idx_t idx, input int n);
        int nxt;
        nxt = int'(idx) + 1;
        return (nxt >= n) ? idx_t'(0) : idx_t'(nxt);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// Requester-side and latch-side signals of the SR latch sequencer.
// master = requesters plus the latch readback; slave = the controller.
interface sr_latch_ctrl_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] op;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic             busy;
    logic             latch_S;
    logic             latch_R;
    logic             latch_clk;
    logic             latch_Q;
    logic             err;

    modport master (
        output req, op, latch_Q,
        input  grant, done, busy, latch_S, latch_R, latch_clk, err
    );

    modport slave (
        input  req, op, latch_Q,
        output grant, done, busy, latch_S, latch_R, latch_clk, err
    );
endinterface

// File: rtl/sr_latch_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted req scanning upward from ptr,
// wrapping modulo N_REQ.
module rr_arbiter
    import sr_latch_ctrl_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  idx_t             ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output idx_t             sel_index
);
    logic found;
    int   pos;

    always_comb begin
        grant_onehot = '0;
        sel_index    = '0;
        found        = 1'b0;
        pos          = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N_REQ) pos = pos - N_REQ;
            // Constant inner index keeps every select static after unrolling.
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && (j == pos) && req[j]) begin
                    found           = 1'b1;
                    grant_onehot[j] = 1'b1;
                    sel_index       = idx_t'(j);
                end
            end
        end
    end
endmodule

// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer sharing one gated SR latch: setup/strobe/hold write cycle.
// Optional latch_Q readback check enabled by defining SR_LATCH_CTRL_READBACK_EN.
module sr_latch_ctrl
    import sr_latch_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input logic           clk,
    input logic           nRst,
    sr_latch_ctrl_if.slave bus
);
    localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    idx_t             ptr_q, ptr_d;
    idx_t             sel_q, sel_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             op_q, op_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             gate_q, gate_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] arb_grant;
    idx_t             arb_sel;
    logic             arb_op;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req          (bus.req),
        .ptr          (ptr_q),
        .grant_onehot (arb_grant),
        .sel_index    (arb_sel)
    );

    assign arb_op = |(bus.op & arb_grant);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        done_d  = '0;
        op_d    = op_q;
        s_d     = s_q;
        r_d     = r_q;
        gate_d  = gate_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_SETUP;
                    grant_d = arb_grant;
                    sel_d   = arb_sel;
                    op_d    = arb_op;
                    s_d     = (arb_op == OP_SET);
                    r_d     = (arb_op == OP_RESET);
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    gate_d  = 1'b1;
                    cnt_d   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    gate_d  = 1'b0;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    grant_d = '0;
                    done_d  = grant_q;
                    ptr_d   = wrap_inc(sel_q, N_REQ);
`ifdef SR_LATCH_CTRL_READBACK_EN
                    // Latch must reflect the op once the gate has closed.
                    if (bus.latch_Q != op_q) err_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            op_q    <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            gate_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            op_q    <= op_d;
            s_q     <= s_d;
            r_q     <= r_d;
            gate_q  <= gate_d;
            err_q   <= err_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.latch_S   = s_q;
    assign bus.latch_R   = r_q;
    assign bus.latch_clk = gate_q;

`ifdef SR_LATCH_CTRL_READBACK_EN
    assign bus.err = err_q;
`else
    logic unused_readback;
    assign unused_readback = bus.latch_Q ^ err_q;
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl: gated SR latch model with forced readback,
// invariant monitor and a linear sequence of hand-computed steps.
module tb_sr_latch_ctrl;
    localparam int N_REQ = 4;
`ifdef SR_LATCH_CTRL_READBACK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk;
    logic nRst;
    logic q_model;
    logic force_en;
    logic force_val;
    logic prev_gate, prev_s, prev_r;
    int   n_cmp;
    int   n_bad;

    sr_latch_ctrl_if #(.N_REQ(N_REQ)) bus ();

    sr_latch_ctrl #(
        .N_REQ(N_REQ), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gated SR latch.
    always @* begin
        if (bus.latch_clk === 1'b1) begin
            if (bus.latch_S === 1'b1 && bus.latch_R === 1'b0) q_model = 1'b1;
            else if (bus.latch_R === 1'b1 && bus.latch_S === 1'b0) q_model = 1'b0;
        end
    end
    assign bus.latch_Q = force_en ? force_val : q_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (bus.busy === 1'b0) break;
            @(negedge clk);
        end
        chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (nRst === 1'b1) begin
            chk("sr_exclusive", {31'd0, bus.latch_S & bus.latch_R}, 32'd0);
            chk("grant_onehot0", {31'd0, $onehot0(bus.grant)}, 32'd1);
            chk("gate_owned", {31'd0, bus.latch_clk ? |bus.grant : 1'b1}, 32'd1);
            if (prev_gate === 1'b1 && bus.latch_clk === 1'b1) begin
                chk("s_stable_gate", {31'd0, bus.latch_S}, {31'd0, prev_s});
                chk("r_stable_gate", {31'd0, bus.latch_R}, {31'd0, prev_r});
            end
            prev_gate <= bus.latch_clk;
            prev_s    <= bus.latch_S;
            prev_r    <= bus.latch_R;
        end else begin
            prev_gate <= 1'b0;
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nRst = 1'b0;
        force_en = 1'b0;
        force_val = 1'b0;
        bus.req = '0;
        bus.op = '0;

        // Reset and idle
        cyc(2);
        chk("rst_grant", {28'd0, bus.grant}, 32'd0);
        chk("rst_done", {28'd0, bus.done}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_srclk", {29'd0, bus.latch_S, bus.latch_R, bus.latch_clk}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        nRst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("idle_gate", {31'd0, bus.latch_clk}, 32'd0);
            chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        end

        // Single set on requester 0
        bus.req = 4'b0001; bus.op = 4'b0001;
        cyc(1);
        chk("set_grant", {28'd0, bus.grant}, 32'h1);
        chk("set_sr_setup", {30'd0, bus.latch_S, bus.latch_R}, 32'b10);
        chk("set_gate_setup", {31'd0, bus.latch_clk}, 32'd0);
        chk("set_busy", {31'd0, bus.busy}, 32'd1);
        bus.op = 4'b0000;
        cyc(1);
        chk("set_gate_t2", {31'd0, bus.latch_clk}, 32'd1);
        chk("set_sr_t2", {30'd0, bus.latch_S, bus.latch_R}, 32'b10);
        cyc(1);
        chk("set_gate_t3", {31'd0, bus.latch_clk}, 32'd1);
        cyc(1);
        chk("set_gate_hold", {31'd0, bus.latch_clk}, 32'd0);
        chk("set_sr_hold", {30'd0, bus.latch_S, bus.latch_R}, 32'b10);
        chk("set_done_early", {28'd0, bus.done}, 32'd0);
        cyc(1);
        chk("set_done", {28'd0, bus.done}, 32'h1);
        chk("set_grant_done", {28'd0, bus.grant}, 32'd0);
        chk("set_sr_done", {30'd0, bus.latch_S, bus.latch_R}, 32'd0);
        chk("set_q", {31'd0, q_model}, 32'd1);
        bus.req = '0;
        cyc(1);
        chk("set_done_pulse", {28'd0, bus.done}, 32'd0);
        chk("set_busy_end", {31'd0, bus.busy}, 32'd0);

        // Readback mismatch: latch Q held at 0 during a set on requester 1
        force_en = 1'b1; force_val = 1'b0;
        bus.req = 4'b0010; bus.op = 4'b0010;
        cyc(1);
        chk("rb_grant", {28'd0, bus.grant}, 32'h2);
        cyc(4);
        chk("rb_done", {28'd0, bus.done}, 32'h2);
        chk("rb_err", {31'd0, bus.err}, {31'd0, EXP_ERR});
        bus.req = '0; force_en = 1'b0;
        cyc(1);
        bus.req = 4'b0100; bus.op = 4'b0000;
        cyc(1);
        chk("rst_op_grant", {28'd0, bus.grant}, 32'h4);
        chk("rst_op_sr", {30'd0, bus.latch_S, bus.latch_R}, 32'b01);
        cyc(4);
        chk("rst_op_done", {28'd0, bus.done}, 32'h4);
        chk("rst_op_q", {31'd0, q_model}, 32'd0);
        chk("rb_err_sticky", {31'd0, bus.err}, {31'd0, EXP_ERR});
        bus.req = '0;
        cyc(1);

        // Reset during strobe on requester 3, then pointer must be back at 0
        bus.req = 4'b1000; bus.op = 4'b1000;
        cyc(1);
        chk("abort_grant", {28'd0, bus.grant}, 32'h8);
        cyc(1);
        chk("abort_gate_pre", {31'd0, bus.latch_clk}, 32'd1);
        #2 nRst = 1'b0;
        #1;
        chk("abort_srclk", {29'd0, bus.latch_S, bus.latch_R, bus.latch_clk}, 32'd0);
        chk("abort_grant0", {28'd0, bus.grant}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_err", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        bus.req = 4'b1010; bus.op = 4'b0000;
        cyc(1);
        chk("ptr_reset_grant", {28'd0, bus.grant}, 32'h2);
        cyc(4);
        chk("ptr_reset_done", {28'd0, bus.done}, 32'h2);
        bus.req = '0;
        cyc(1);

        // Round robin with all four requesting
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        bus.req = 4'b1111; bus.op = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            logic       ob;
            oh = 4'b0001 << (k % 4);
            ob = ((k % 2) == 0);
            cyc(1);
            chk("rr_grant", {28'd0, bus.grant}, {28'd0, oh});
            chk("rr_sr", {30'd0, bus.latch_S, bus.latch_R}, {30'd0, ob, ~ob});
            cyc(4);
            chk("rr_done", {28'd0, bus.done}, {28'd0, oh});
            chk("rr_q", {31'd0, q_model}, {31'd0, ob});
            cyc(1);
            chk("rr_idle", {31'd0, bus.busy}, 32'd0);
        end
        bus.req = '0;
        wait_idle();

        // Random traffic under the invariant monitor
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus.req = 4'($urandom_range(0, 15));
            bus.op  = 4'($urandom_range(0, 15));
        end
        bus.req = '0;
        @(negedge clk);
        wait_idle();
        chk("final_gate", {31'd0, bus.latch_clk}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
